axi_rd_burst_sched: RTL and testbench

//   Command scheduler in front of the AXI native read engine. Accepts one DMA read

---
 rtl/axi_rd_burst_sched.sv | 146 ++++++++++++++
 tb/tb_axi_rd_burst_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_burst_sched.sv
// axi_rd_burst_sched
// Splits one DMA read command (start address + beat count) into AXI INCR
// bursts that never exceed MAX_BURST beats and never cross a 4 KB page.
// Bursts go to the read engine one at a time; each must complete before the
// next is issued. done pulses once the final burst has completed.
module axi_rd_burst_sched #(
  parameter int ADDR_WDTH = 32,
  parameter int DATA_WDTH = 32,
  parameter int LEN_WDTH  = 24,
  parameter int MAX_BURST = 256
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst_n,
  input  logic                 soft_rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [ADDR_WDTH-1:0] cmd_addr,
  input  logic [LEN_WDTH-1:0]  cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 rstart_vld,
  input  logic                 rstart_rdy,
  output logic [ADDR_WDTH-1:0] raddr,
  output logic [7:0]           rburst_len,
  output logic [15:0]          dbg_burst_cnt
);

  localparam int BYTES = DATA_WDTH / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [ADDR_WDTH-1:0] cur_addr;
  logic [LEN_WDTH-1:0]  rem;
  logic [8:0]           beats;
  logic [12:0]          bnd;
  logic [8:0]           beats_calc;
  logic                 hshake;
  logic [ADDR_WDTH-1:0] addr_aligned;

  // Smallest of remaining beats, MAX_BURST and beats left in the 4 KB page.
  // Result is always 1..MAX_BURST because rem > 0 and bnd >= 1 whenever used.
  function automatic logic [8:0] clamp_beats(input logic [LEN_WDTH-1:0] r,
                                             input logic [12:0]         b);
    logic [8:0] m;
    m = 9'(MAX_BURST);
    if (b < 13'(MAX_BURST)) m = b[8:0];
    if (r < LEN_WDTH'(m))   m = r[8:0];
    return m;
  endfunction

  // Beats remaining before the next 4 KB boundary, plus the clamped burst size.
  always_comb begin
    bnd          = (13'd4096 - {1'b0, cur_addr[11:0]}) >> BSH;
    beats_calc   = clamp_beats(rem, bnd);
    hshake       = rstart_vld & rstart_rdy;
    addr_aligned = cmd_addr & ~ADDR_WDTH'(BYTES - 1);
  end

  // State register.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; soft_rst overrides every transition.
  always_comb begin
    state_nxt = state;
    if (soft_rst) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cmd_vld) state_nxt = (cmd_len == '0) ? S_DONE : S_CALC;
        S_CALC:  state_nxt = S_ISSUE;
        S_ISSUE: if (hshake) state_nxt = S_WAIT;
        S_WAIT:  if (rstart_rdy) state_nxt = (rem == '0) ? S_DONE : S_CALC;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Decoded outputs: ready only while idle, busy otherwise.
  always_comb begin
    cmd_rdy = (state == S_IDLE);
    busy    = (state != S_IDLE);
  end

  // Control registers: request valid, done pulse, remaining beats, burst count.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      rstart_vld    <= 1'b0;
      done          <= 1'b0;
      rem           <= '0;
      dbg_burst_cnt <= '0;
    end else begin
      rstart_vld <= (state_nxt == S_ISSUE);
      done       <= (state_nxt == S_DONE);
      if (soft_rst) begin
        rem <= '0;
      end else begin
        case (state)
          S_IDLE: if (cmd_vld) rem <= cmd_len;
          S_ISSUE: begin
            if (hshake) begin
              rem           <= rem - LEN_WDTH'(beats);
              dbg_burst_cnt <= dbg_burst_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Address registers: running address, and burst fields held through ISSUE.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      cur_addr   <= '0;
      raddr      <= '0;
      rburst_len <= '0;
      beats      <= '0;
    end else if (!soft_rst) begin
      case (state)
        S_IDLE: if (cmd_vld) cur_addr <= addr_aligned;
        S_CALC: begin
          raddr      <= cur_addr;
          rburst_len <= 8'(beats_calc - 9'd1);
          beats      <= beats_calc;
        end
        S_ISSUE: if (hshake) cur_addr <= cur_addr + (ADDR_WDTH'(beats) << BSH);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Bench for axi_rd_burst_sched: directed table, abort sequence and random
// commands, all checked against a page/max-burst splitting model.
module tb_axi_rd_burst_sched;

  logic        axi_clk;
  logic        axi_rst_n;
  logic        soft_rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_len;
  logic        busy;
  logic        done;
  logic        rstart_vld;
  logic        rstart_rdy;
  logic [31:0] raddr;
  logic [7:0]  rburst_len;
  logic [15:0] dbg_burst_cnt;

  axi_rd_burst_sched #(
    .ADDR_WDTH(32), .DATA_WDTH(32), .LEN_WDTH(24), .MAX_BURST(256)
  ) dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .soft_rst(soft_rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .rstart_vld(rstart_vld), .rstart_rdy(rstart_rdy),
    .raddr(raddr), .rburst_len(rburst_len), .dbg_burst_cnt(dbg_burst_cnt)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    logic [23:0] len;
    int          stall;
    logic [31:0] a0;
    logic [7:0]  l0;
  } vec_t;

  int          vec_cnt;
  int          err_cnt;
  logic [15:0] exp_cnt;
  burst_t      exp_q[$];
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: walk the command in page-limited, max-burst-limited chunks.
  task automatic model(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int r, room, b;
    exp_q.delete();
    a = addr & 32'hFFFF_FFFC;
    r = len;
    while (r > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = r;
      if (b > 256)  b = 256;
      if (b > room) b = room;
      exp_q.push_back('{a: a, l: 8'(b - 1)});
      a = a + 32'(b * 4);
      r = r - b;
    end
  endtask

  // Called at the first negedge where the burst request should be visible.
  // Returns just before the completion edge, or after an abort.
  task automatic do_burst(input burst_t e, input int stall, input int wl, input bit abort);
    chk("req_vld", 32'(rstart_vld), 32'd1);
    chk("raddr", raddr, e.a);
    chk("rburst_len", 32'(rburst_len), 32'(e.l));
    if (stall > 0) begin
      rstart_rdy = 1'b0;
      repeat (stall) begin
        @(negedge axi_clk);
        chk("stall_vld", 32'(rstart_vld), 32'd1);
        chk("stall_raddr", raddr, e.a);
        chk("stall_rlen", 32'(rburst_len), 32'(e.l));
        chk("stall_cnt", 32'(dbg_burst_cnt), 32'(exp_cnt));
      end
      rstart_rdy = 1'b1;
    end
    @(negedge axi_clk);
    exp_cnt    = exp_cnt + 16'd1;
    rstart_rdy = 1'b0;
    chk("wait_vld", 32'(rstart_vld), 32'd0);
    chk("burst_cnt", 32'(dbg_burst_cnt), 32'(exp_cnt));
    if (abort) begin
      soft_rst = 1'b1;
      @(negedge axi_clk);
      soft_rst = 1'b0;
      chk("abort_rdy", 32'(cmd_rdy), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_vld", 32'(rstart_vld), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      rstart_rdy = 1'b1;
      repeat (3) begin
        @(negedge axi_clk);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_vld", 32'(rstart_vld), 32'd0);
        chk("post_abort_rdy", 32'(cmd_rdy), 32'd1);
      end
      chk("abort_cnt", 32'(dbg_burst_cnt), 32'(exp_cnt));
      return;
    end
    cmd_vld  = 1'b1;
    cmd_addr = $urandom;
    cmd_len  = 24'($urandom);
    repeat (wl) begin
      @(negedge axi_clk);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_rdy", 32'(cmd_rdy), 32'd0);
      chk("wait_vld2", 32'(rstart_vld), 32'd0);
      chk("wait_done", 32'(done), 32'd0);
    end
    cmd_vld    = 1'b0;
    rstart_rdy = 1'b1;
  endtask

  // Runs one command from acceptance through done (or abort after burst abort_at).
  task automatic run_cmd(input logic [31:0] addr, input logic [23:0] len, input int stall,
                         input bit chk_first, input logic [31:0] a0, input logic [7:0] l0,
                         input int abort_at);
    model(addr, int'(len));
    chk("idle_rdy", 32'(cmd_rdy), 32'd1);
    cmd_vld  = 1'b1;
    cmd_addr = addr;
    cmd_len  = len;
    @(negedge axi_clk);
    cmd_vld = 1'b0;
    if (exp_q.size() == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_vld", 32'(rstart_vld), 32'd0);
      @(negedge axi_clk);
      chk("zero_done_end", 32'(done), 32'd0);
      chk("zero_vld_end", 32'(rstart_vld), 32'd0);
      chk("zero_rdy", 32'(cmd_rdy), 32'd1);
      return;
    end
    chk("calc_vld", 32'(rstart_vld), 32'd0);
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_rdy", 32'(cmd_rdy), 32'd0);
    @(negedge axi_clk);
    if (chk_first) begin
      chk("tbl_raddr", raddr, a0);
      chk("tbl_rlen", 32'(rburst_len), 32'(l0));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        do_burst(exp_q[i], 0, 1, 1'b1);
        return;
      end
      do_burst(exp_q[i], (i == 0) ? stall : 0, int'($urandom_range(1, 4)), 1'b0);
      @(negedge axi_clk);
      if (i == exp_q.size() - 1) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_vld", 32'(rstart_vld), 32'd0);
        @(negedge axi_clk);
        chk("done_end", 32'(done), 32'd0);
        chk("done_rdy", 32'(cmd_rdy), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
      end else begin
        chk("calc2_vld", 32'(rstart_vld), 32'd0);
        chk("calc2_done", 32'(done), 32'd0);
        @(negedge axi_clk);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    vec_cnt    = 0;
    err_cnt    = 0;
    exp_cnt    = 16'd0;
    axi_rst_n  = 1'b0;
    soft_rst   = 1'b0;
    cmd_vld    = 1'b0;
    cmd_addr   = 32'd0;
    cmd_len    = 24'd0;
    rstart_rdy = 1'b1;

    tbl[0] = '{addr: 32'h0000_1000, len: 24'd16,  stall: 0, a0: 32'h0000_1000, l0: 8'd15};
    tbl[1] = '{addr: 32'h0000_0FF0, len: 24'd16,  stall: 0, a0: 32'h0000_0FF0, l0: 8'd3};
    tbl[2] = '{addr: 32'h0000_0000, len: 24'd600, stall: 0, a0: 32'h0000_0000, l0: 8'd255};
    tbl[3] = '{addr: 32'h0000_0040, len: 24'd0,   stall: 0, a0: 32'h0,         l0: 8'd0};
    tbl[4] = '{addr: 32'h0000_2000, len: 24'd8,   stall: 5, a0: 32'h0000_2000, l0: 8'd7};
    tbl[5] = '{addr: 32'hFFFF_FFF0, len: 24'd8,   stall: 0, a0: 32'hFFFF_FFF0, l0: 8'd3};
    tbl[6] = '{addr: 32'h0000_1003, len: 24'd2,   stall: 1, a0: 32'h0000_1000, l0: 8'd1};
    tbl[7] = '{addr: 32'h0000_0FFC, len: 24'd1,   stall: 0, a0: 32'h0000_0FFC, l0: 8'd0};

    repeat (2) @(negedge axi_clk);
    chk("rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vld", 32'(rstart_vld), 32'd0);
    chk("rst_raddr", raddr, 32'd0);
    chk("rst_rlen", 32'(rburst_len), 32'd0);
    chk("rst_cnt", 32'(dbg_burst_cnt), 32'd0);
    axi_rst_n = 1'b1;
    @(negedge axi_clk);

    for (int i = 0; i < 8; i++)
      run_cmd(tbl[i].addr, tbl[i].len, tbl[i].stall, (tbl[i].len != 0),
              tbl[i].a0, tbl[i].l0, -1);

    // Abort in the wait phase of the second burst, then a normal command.
    run_cmd(32'h0, 24'd600, 0, 1'b1, 32'h0, 8'd255, 1);
    run_cmd(32'h0000_3000, 24'd4, 0, 1'b1, 32'h0000_3000, 8'd3, -1);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      run_cmd(ra, 24'($urandom_range(0, 700)), int'($urandom_range(0, 3)),
              1'b0, 32'h0, 8'h0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
